// File: rtl/branch_resolve_unit_if.sv
// Handshake and datapath bundle between the EX stage, the compare unit,
// the branch resolve unit and the fetch stage.
interface branch_resolve_unit_if #(
    parameter int CNT_W = 16
);
    // EX-side instruction slot
    logic             ex_valid;
    logic             ex_ready;
    logic [2:0]       ex_br_type;
    logic [31:0]      ex_pc;
    logic [15:0]      ex_imm;
    logic [31:0]      ex_rs_val;
    // Compare-unit flags and operand sign bits
    logic             cmp_eq;
    logic             cmp_lt_u;
    logic             a_msb;
    logic             b_msb;
    // Redirect channel to fetch
    logic             redirect_valid;
    logic             redirect_ready;
    logic [31:0]      redirect_pc;
    logic             flush;
    // Statistics
    logic [CNT_W-1:0] taken_cnt;

    // Pipeline side: drives the EX slot and fetch readiness, observes results
    modport master (
        output ex_valid, ex_br_type, ex_pc, ex_imm, ex_rs_val,
        output cmp_eq, cmp_lt_u, a_msb, b_msb,
        output redirect_ready,
        input  ex_ready, redirect_valid, redirect_pc, flush, taken_cnt
    );

    // Branch resolve unit side
    modport slave (
        input  ex_valid, ex_br_type, ex_pc, ex_imm, ex_rs_val,
        input  cmp_eq, cmp_lt_u, a_msb, b_msb,
        input  redirect_ready,
        output ex_ready, redirect_valid, redirect_pc, flush, taken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decides taken/not-taken from compare flags,
// computes the target, and holds a registered redirect + one-cycle flush
// toward fetch until it is accepted. Also counts taken branches (saturating).
module branch_resolve_unit #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave brif
);

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;
    localparam logic [2:0] BR_JR   = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q;
    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic             flush_q;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] taken_cnt_d;

    logic             lt_s;
    logic             taken;
    logic [31:0]      offset;
    logic [31:0]      target;
    logic             ex_ready;
    logic             accept;
    logic             take;

    // While HOLD is blocked by fetch, EX is stalled so its inputs are ignored.
    assign ex_ready = (state_q == IDLE) | brif.redirect_ready;
    assign accept   = brif.ex_valid & ex_ready;
    assign take     = accept & taken;

    // Branch condition and target resolution for the instruction in EX
    always_comb begin
        lt_s   = (brif.a_msb ^ brif.b_msb) ? brif.a_msb : brif.cmp_lt_u;
        taken  = 1'b0;
        offset = {{14{brif.ex_imm[15]}}, brif.ex_imm, 2'b00};
        target = brif.ex_pc + 32'd4 + offset;
        case (brif.ex_br_type)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = brif.cmp_eq;
            BR_BNE:  taken = ~brif.cmp_eq;
            BR_BLEZ: taken = lt_s | brif.cmp_eq;
            BR_BGTZ: taken = ~(lt_s | brif.cmp_eq);
            BR_BLTZ: taken = lt_s;
            BR_BGEZ: taken = ~lt_s;
            BR_JR: begin
                taken  = 1'b1;
                target = brif.ex_rs_val;
            end
            default: taken = 1'b0;
        endcase
    end

    // Saturating taken counter: sticks at all-ones instead of wrapping
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (take && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Redirect FSM with registered redirect_valid/redirect_pc/flush outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
            flush_q          <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q          <= HOLD;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= target;
                        flush_q          <= 1'b1;
                    end
                end
                HOLD: begin
                    if (brif.redirect_ready) begin
                        if (take) begin
                            // Handshake completes and a new redirect replaces it
                            redirect_pc_q <= target;
                            flush_q       <= 1'b1;
                        end else begin
                            state_q          <= IDLE;
                            redirect_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Statistics counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt_q <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign brif.ex_ready       = ex_ready;
    assign brif.redirect_valid = redirect_valid_q;
    assign brif.redirect_pc    = redirect_pc_q;
    assign brif.flush          = flush_q;
    assign brif.taken_cnt      = taken_cnt_q;

endmodule
